// File: rtl/axis_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module      : axis_pipe_slice
// Description : AXI4-Stream register slice built from STAGES cascaded
//               full-throughput skid stages. Both the forward path
//               (tvalid/payload) and the backward path (tready) are
//               registered at every stage, and 1 beat/clk is sustained.
//               Capacity is 2*STAGES words.
//
// Parameters  : DATA_WIDTH  tdata width (multiple of 8), tkeep = DATA_WIDTH/8
//               USER_WIDTH  tuser width (>= 1)
//               STAGES      number of skid stages, 1..8
//
// Ports       : clk, reset                 clock, async active-high reset
//               s_axis_t{data,keep,user,last,valid} / s_axis_tready   upstream
//               m_axis_t{data,keep,user,last,valid} / m_axis_tready   downstream
//
// Option      : AXIS_PIPE_STATS_EN (define to enable)
//               adds stats_clear (in), beat_count / pkt_count (out, 32 bit),
//               counting downstream beats and tlast beats.
//
// Revision    : 1.0  initial release
// ============================================================================
module axis_pipe_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int STAGES     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
`ifdef AXIS_PIPE_STATS_EN
    ,
    input  logic                    stats_clear,
    output logic [31:0]             beat_count,
    output logic [31:0]             pkt_count
`endif
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int PW     = DATA_WIDTH + KEEP_W + USER_WIDTH + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Inter-stage links. Index g is the input of stage g; index STAGES is the
    // downstream port. Ready at index g is the registered ready of stage g.
    logic [PW-1:0] stg_data  [0:STAGES];
    logic          stg_valid [0:STAGES];
    logic          stg_ready [0:STAGES];

    assign stg_data[0]       = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    assign stg_valid[0]      = s_axis_tvalid;
    assign s_axis_tready     = stg_ready[0];
    assign stg_ready[STAGES] = m_axis_tready;

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = stg_data[STAGES];
    assign m_axis_tvalid = stg_valid[STAGES];

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            state_t        state_q, state_d;
            logic [PW-1:0] main_q, main_d;
            logic [PW-1:0] skid_q, skid_d;
            logic          ready_q;
            logic          in_beat;
            logic          out_beat;

            assign in_beat  = stg_valid[g] & ready_q;
            assign out_beat = (state_q != EMPTY) & stg_ready[g+1];

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                unique case (state_q)
                    EMPTY: begin
                        if (in_beat) begin
                            state_d = BUSY;
                            main_d  = stg_data[g];
                        end
                    end
                    BUSY: begin
                        if (in_beat && !out_beat) begin
                            // Downstream stalled: park the new word in the skid
                            state_d = FULL;
                            skid_d  = stg_data[g];
                        end else if (out_beat && !in_beat) begin
                            state_d = EMPTY;
                        end else if (in_beat && out_beat) begin
                            main_d  = stg_data[g];
                        end
                    end
                    FULL: begin
                        // ready_q is low here, so no input can arrive
                        if (out_beat) begin
                            state_d = BUSY;
                            main_d  = skid_q;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    // Ready is registered from the next state, so the skid
                    // register always has room for the one word that can
                    // arrive while this stage's ready is still high.
                    ready_q <= (state_d != FULL);
                end
            end

            assign stg_ready[g]   = ready_q;
            assign stg_valid[g+1] = (state_q != EMPTY);
            assign stg_data[g+1]  = main_q;
        end
    endgenerate

`ifdef AXIS_PIPE_STATS_EN
    logic        m_beat;
    logic [31:0] beat_count_q;
    logic [31:0] pkt_count_q;

    assign m_beat = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else if (stats_clear) begin
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else if (m_beat) begin
            beat_count_q <= beat_count_q + 32'd1;
            if (m_axis_tlast) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign beat_count = beat_count_q;
    assign pkt_count  = pkt_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_pipe_slice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axis_pipe_slice
// Description : Self-checking bench for axis_pipe_slice (STAGES=3). A queue
//               reference model records every accepted upstream word and
//               expects the same words, in order, downstream. Also checks
//               reset values, latency, throughput, capacity, stall stability,
//               mid-packet reset and (when AXIS_PIPE_STATS_EN) the counters.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axis_pipe_slice;

    localparam int DW  = 32;
    localparam int UW  = 2;
    localparam int ST  = 3;
    localparam int KW  = DW / 8;
    localparam int PWD = DW + KW + UW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
`ifdef AXIS_PIPE_STATS_EN
    logic          stats_clear;
    logic [31:0]   beat_count;
    logic [31:0]   pkt_count;
`endif

    axis_pipe_slice #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .STAGES     (ST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
`ifdef AXIS_PIPE_STATS_EN
        ,
        .stats_clear   (stats_clear),
        .beat_count    (beat_count),
        .pkt_count     (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    logic [PWD-1:0] s_word;
    logic [PWD-1:0] m_word;
    assign s_word = {s_tdata, s_tkeep, s_tuser, s_tlast};
    assign m_word = {m_tdata, m_tkeep, m_tuser, m_tlast};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model and monitor state
    logic [PWD-1:0] exp_q[$];
    logic [PWD-1:0] prev_word;
    bit             prev_stall = 1'b0;
    bit             s_acc      = 1'b0;
    int             s_beats    = 0;
    int             m_beats    = 0;
    int             cyc        = 0;
    int             last_m_cyc = -1;
    int             gaps       = 0;

    // Driver state
    int             remaining  = 0;
    int             pkt_idx    = 0;
    bit             inc_data   = 1'b0;
    logic [DW-1:0]  seq_data   = '0;

    // Monitor: inputs change only #1 after a rising edge, so values seen on
    // the falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
            s_acc      = 1'b0;
        end else begin
            s_acc = s_tvalid & s_tready;
            if (prev_stall) begin
                chk("stall_valid",   64'(m_tvalid), 64'd1);
                chk("stall_payload", 64'(m_word),   64'(prev_word));
            end
            if (s_acc) begin
                exp_q.push_back(s_word);
                s_beats++;
            end
            if (m_tvalid && m_tready) begin
                m_beats++;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    chk("sb_word", 64'(m_word), 64'(exp_q.pop_front()));
                end
                if (last_m_cyc >= 0 && cyc != last_m_cyc + 1) gaps++;
                last_m_cyc = cyc;
            end
            prev_stall = m_tvalid & ~m_tready;
            prev_word  = m_word;
        end
    end

    // One clock of stimulus: retire an accepted word, maybe offer a new one,
    // and pick the downstream ready. pv/pr are percentages.
    task automatic step(input int pv, input int pr);
        @(posedge clk);
        #1;
        if (s_tvalid && s_acc) s_tvalid = 1'b0;
        if (!s_tvalid && remaining > 0 && $urandom_range(99) < pv) begin
            if (inc_data) begin
                s_tdata  = seq_data;
                seq_data = seq_data + 1'b1;
            end else begin
                s_tdata = $urandom;
            end
            s_tkeep   = KW'($urandom);
            s_tuser   = UW'($urandom);
            s_tlast   = (pkt_idx % 8 == 7);
            pkt_idx++;
            s_tvalid  = 1'b1;
            remaining--;
        end
        m_tready = ($urandom_range(99) < pr);
    endtask

    task automatic drain(input int pv, input int pr, input int maxc, input string tag);
        int n = 0;
        while ((remaining > 0 || s_tvalid || exp_q.size() != 0) && n < maxc) begin
            step(pv, pr);
            n++;
        end
        chk({tag, "_done_in_budget"}, 64'(n < maxc), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        reset    = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
`ifdef AXIS_PIPE_STATS_EN
        stats_clear = 1'b0;
`endif

        // 1: reset values, ready rises one edge after release
        repeat (5) begin
            @(negedge clk);
            chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
            chk("rst_s_tready", 64'(s_tready), 64'd0);
            chk("rst_m_word",   64'(m_word),   64'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rel_s_tready_before_edge", 64'(s_tready), 64'd0);
        @(negedge clk);
        chk("rel_s_tready_after_edge", 64'(s_tready), 64'd1);
        chk("rel_m_tvalid", 64'(m_tvalid), 64'd0);

        // 2: single-beat latency through STAGES stages
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        s_tdata  = 32'hA5A5_0001;
        s_tkeep  = 4'hF;
        s_tuser  = 2'd1;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (m_tvalid) break;
            @(posedge clk);
            lat++;
        end
        chk("latency_clks", 64'(lat), 64'(ST));
        chk("latency_data", 64'(m_tdata), 64'hA5A5_0001);
        repeat (3) @(posedge clk);
        chk("latency_drained", 64'(exp_q.size()), 64'd0);

        // 3: back-to-back streaming, no bubbles
        #1;
        inc_data   = 1'b1;
        seq_data   = 32'h0000_1000;
        pkt_idx    = 0;
        last_m_cyc = -1;
        gaps       = 0;
        base       = m_beats;
        remaining  = 256;
        drain(100, 100, 400, "stream");
        chk("stream_count", 64'(m_beats - base), 64'd256);
        chk("stream_gaps",  64'(gaps), 64'd0);
        inc_data = 1'b0;

        // 4: backpressure fills exactly 2*STAGES words, then drains in order
        pkt_idx   = 0;
        base      = s_beats;
        remaining = 2 * ST + 1;
        repeat (20) step(100, 0);
        chk("bp_accepted", 64'(s_beats - base), 64'(2 * ST));
        @(negedge clk);
        chk("bp_s_tready", 64'(s_tready), 64'd0);
        chk("bp_m_tvalid", 64'(m_tvalid), 64'd1);
        drain(100, 100, 200, "bp");
        chk("bp_total", 64'(s_beats - base), 64'(2 * ST + 1));

        // 5: random valid/ready, 8-beat packets
        pkt_idx = 0;
`ifdef AXIS_PIPE_STATS_EN
        @(posedge clk);
        #1 stats_clear = 1'b1;
        @(posedge clk);
        #1 stats_clear = 1'b0;
        chk("stats_cleared_beats", 64'(beat_count), 64'd0);
        chk("stats_cleared_pkts",  64'(pkt_count),  64'd0);
`endif
        base      = m_beats;
        remaining = 10000;
        drain(50, 50, 80000, "rand");
        chk("rand_beats", 64'(m_beats - base), 64'd10000);
`ifdef AXIS_PIPE_STATS_EN
        chk("stats_beat_count", 64'(beat_count), 64'd10000);
        chk("stats_pkt_count",  64'(pkt_count),  64'd1250);
`endif

        // 6: reset in the middle of a packet discards in-flight words
        pkt_idx   = 0;
        base      = s_beats;
        remaining = 8;
        lat       = 0;
        while (s_beats - base < 3 && lat < 50) begin
            step(100, 0);
            lat++;
        end
        chk("mid_three_accepted", 64'(s_beats - base), 64'd3);
        reset     = 1'b1;
        s_tvalid  = 1'b0;
        remaining = 0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_m_word",   64'(m_word),   64'd0);
        chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        m_tready = 1'b1;
        base     = m_beats;
        repeat (20) @(posedge clk);
        chk("mid_no_stale_beats", 64'(m_beats - base), 64'd0);
        #1;
        remaining = 1;
        drain(100, 100, 50, "post_rst");
        chk("post_rst_one_beat", 64'(m_beats - base), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
